// File: rtl/seg_scan_capture_if.sv
// Seven-segment display nets as seen by the capture block, plus the decoded frame it returns.
// The master side drives the display nets and the slave side captures them.
interface seg_scan_capture_if;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic [15:0] digits;
    logic [3:0]  dp_out;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        err;

    modport master (
        output seg, an, dp,
        input  digits, dp_out, digit_valid, frame_done, err
    );

    modport slave (
        input  seg, an, dp,
        output digits, dp_out, digit_valid, frame_done, err
    );
endinterface

// File: rtl/seg_scan_capture.sv
// Captures a multiplexed seven-segment scan: waits for each slot to settle, decodes the glyph
// back to a hex nibble and assembles a four-digit frame with per-digit validity.
module seg_scan_capture #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic              MCLK,
    input  logic              reset,
    seg_scan_capture_if.slave bus
);

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } sample_t;

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] nibble;
    } glyph_t;

    localparam sample_t    IDLE_SAMPLE = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};
    localparam logic [7:0] CNT_SAT     = 8'(SETTLE_CYCLES);
    localparam logic [7:0] CNT_PRE_CAP = 8'(SETTLE_CYCLES - 2);

    // Maps an active-low g..a pattern to its hex value; anything unknown is reported illegal.
    function automatic glyph_t decode_glyph(input logic [6:0] pattern);
        glyph_t g;
        g = '{legal: 1'b1, blank: 1'b0, nibble: 4'h0};
        case (pattern)
            7'h40: g.nibble = 4'h0;
            7'h79: g.nibble = 4'h1;
            7'h24: g.nibble = 4'h2;
            7'h30: g.nibble = 4'h3;
            7'h19: g.nibble = 4'h4;
            7'h12: g.nibble = 4'h5;
            7'h02: g.nibble = 4'h6;
            7'h78: g.nibble = 4'h7;
            7'h00: g.nibble = 4'h8;
            7'h10: g.nibble = 4'h9;
            7'h08: g.nibble = 4'hA;
            7'h03: g.nibble = 4'hB;
            7'h46: g.nibble = 4'hC;
            7'h21: g.nibble = 4'hD;
            7'h06: g.nibble = 4'hE;
            7'h0E: g.nibble = 4'hF;
            7'h7F: begin
                g.legal = 1'b0;
                g.blank = 1'b1;
            end
            default: g.legal = 1'b0;
        endcase
        return g;
    endfunction

    sample_t     in_q;
    sample_t     prev_q;
    logic [7:0]  stable_cnt;

    logic [15:0] digits_q,  digits_n;
    logic [3:0]  dp_q,      dp_n;
    logic [3:0]  valid_q,   valid_n;
    logic [3:0]  seen_q,    seen_n;
    logic        frame_q,   frame_n;
    logic        err_q,     err_n;

    logic        same_sample;
    logic        capture;
    logic [3:0]  slot_oh;
    logic [2:0]  low_count;
    glyph_t      glyph;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            in_q   <= IDLE_SAMPLE;
            prev_q <= IDLE_SAMPLE;
        end else begin
            in_q   <= '{an: bus.an, seg: bus.seg, dp: bus.dp};
            prev_q <= in_q;
        end
    end

    assign same_sample = (in_q == prev_q);

    // Saturating run counter: a held value can only reach the capture point once.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            stable_cnt <= 8'd0;
        end else if (!same_sample) begin
            stable_cnt <= 8'd0;
        end else if (stable_cnt != CNT_SAT) begin
            stable_cnt <= stable_cnt + 8'd1;
        end
    end

    assign capture   = same_sample && (stable_cnt == CNT_PRE_CAP);
    assign slot_oh   = ~in_q.an;
    assign low_count = 3'($countones(slot_oh));
    assign glyph     = decode_glyph(in_q.seg);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        digits_n = digits_q;
        dp_n     = dp_q;
        valid_n  = valid_q;
        seen_n   = seen_q;
        err_n    = err_q;
        frame_n  = 1'b0;

        if (capture) begin
            if (low_count >= 3'd2) begin
                err_n = 1'b1;
            end else if (low_count == 3'd1) begin
                for (int i = 0; i < 4; i++) begin
                    if (slot_oh[i]) begin
                        digits_n[4*i +: 4] = glyph.nibble;
                        valid_n[i]         = glyph.legal;
                        dp_n[i]            = ~in_q.dp;
                    end
                end
                if (!glyph.legal && !glyph.blank) begin
                    err_n = 1'b1;
                end
                seen_n = seen_q | slot_oh;
                if (seen_n == 4'hF) begin
                    frame_n = 1'b1;
                    seen_n  = 4'h0;
                end
            end
        end
    end

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            digits_q <= 16'h0000;
            dp_q     <= 4'h0;
            valid_q  <= 4'h0;
            seen_q   <= 4'h0;
            frame_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            digits_q <= digits_n;
            dp_q     <= dp_n;
            valid_q  <= valid_n;
            seen_q   <= seen_n;
            frame_q  <= frame_n;
            err_q    <= err_n;
        end
    end

    assign bus.digits      = digits_q;
    assign bus.dp_out      = dp_q;
    assign bus.digit_valid = valid_q;
    assign bus.frame_done  = frame_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: directed vector table, hand sequences for frame
// tracking corners, and randomized scans compared against a run-length reference model.
module tb_seg_scan_capture;

    localparam int SETTLE = 4;

    logic MCLK;
    logic reset;

    seg_scan_capture_if bus ();

    seg_scan_capture #(.SETTLE_CYCLES(SETTLE)) dut (
        .MCLK  (MCLK),
        .reset (reset),
        .bus   (bus)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    int total = 0;
    int bad   = 0;
    int fd_cnt = 0;

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: counts identical consecutive input samples; the S-th identical sample
    // schedules a capture that becomes visible one edge later.
    logic [6:0] glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [15:0] m_digits;
    logic [3:0]  m_valid, m_dp, m_seen;
    logic        m_err, m_fd;
    logic [11:0] m_last;
    int          m_run;
    logic        pend;
    logic [11:0] pend_val;

    task automatic model_reset();
        m_digits = '0; m_valid = '0; m_dp = '0; m_seen = '0;
        m_err = 1'b0; m_fd = 1'b0;
        m_last = {4'hF, 7'h7F, 1'b1};
        m_run = 0;
        pend = 1'b0;
        pend_val = '0;
    endtask

    task automatic model_apply(input logic [11:0] v);
        logic [3:0] a;
        logic [6:0] s;
        int lows, idx, found;
        a = v[11:8];
        s = v[7:1];
        lows = 0;
        idx = 0;
        for (int i = 0; i < 4; i++) if (a[i] == 1'b0) begin lows++; idx = i; end
        if (lows >= 2) begin
            m_err = 1'b1;
        end else if (lows == 1) begin
            found = -1;
            for (int k = 0; k < 16; k++) if (glyphs[k] == s) found = k;
            if (found >= 0) begin
                m_digits[idx*4 +: 4] = 4'(found);
                m_valid[idx] = 1'b1;
            end else begin
                m_digits[idx*4 +: 4] = 4'h0;
                m_valid[idx] = 1'b0;
                if (s != 7'h7F) m_err = 1'b1;
            end
            m_dp[idx] = ~v[0];
            m_seen[idx] = 1'b1;
            if (m_seen == 4'hF) begin
                m_fd = 1'b1;
                m_seen = 4'h0;
            end
        end
    endtask

    task automatic step(input logic [3:0] a, input logic [6:0] s, input logic d);
        bus.an = a; bus.seg = s; bus.dp = d;
        @(posedge MCLK);
        m_fd = 1'b0;
        if (pend) begin
            model_apply(pend_val);
            pend = 1'b0;
        end
        if ({a, s, d} == m_last) begin
            if (m_run < 1000000) m_run++;
        end else begin
            m_run = 1;
            m_last = {a, s, d};
        end
        if (m_run == SETTLE) begin
            pend = 1'b1;
            pend_val = {a, s, d};
        end
        #1;
        check("m_digits", bus.digits, m_digits);
        check("m_valid", 16'(bus.digit_valid), 16'(m_valid));
        check("m_dp", 16'(bus.dp_out), 16'(m_dp));
        check("m_err", 16'(bus.err), 16'(m_err));
        check("m_frame", 16'(bus.frame_done), 16'(m_fd));
        if (bus.frame_done) fd_cnt++;
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
        for (int i = 0; i < n; i++) step(a, s, d);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_digits", bus.digits, 16'h0000);
        check("rst_valid", 16'(bus.digit_valid), 16'h0);
        check("rst_dp", 16'(bus.dp_out), 16'h0);
        check("rst_frame", 16'(bus.frame_done), 16'h0);
        check("rst_err", 16'(bus.err), 16'h0);
        repeat (2) @(posedge MCLK);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        bit          rst;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        int          cycles;
        logic [15:0] exp_digits;
        logic [3:0]  exp_valid;
        logic [3:0]  exp_dp;
        logic        exp_err;
        int          exp_fd;
    } vec_t;

    vec_t vecs [12];

    initial begin
        reset = 1'b0;
        bus.an = 4'hF; bus.seg = 7'h7F; bus.dp = 1'b1;

        // Basic frame, sticky error on two anodes, blank vs illegal glyph, decimal point slot.
        vecs[0]  = '{1'b1, 4'hE, 7'h79, 1'b1, 8, 16'h0001, 4'b0001, 4'b0000, 1'b0, 0};
        vecs[1]  = '{1'b0, 4'hD, 7'h24, 1'b1, 8, 16'h0021, 4'b0011, 4'b0000, 1'b0, 0};
        vecs[2]  = '{1'b0, 4'hB, 7'h30, 1'b1, 8, 16'h0321, 4'b0111, 4'b0000, 1'b0, 0};
        vecs[3]  = '{1'b0, 4'h7, 7'h19, 1'b1, 8, 16'h4321, 4'b1111, 4'b0000, 1'b0, 1};
        vecs[4]  = '{1'b0, 4'hC, 7'h40, 1'b1, 8, 16'h4321, 4'b1111, 4'b0000, 1'b1, 0};
        vecs[5]  = '{1'b0, 4'hE, 7'h06, 1'b1, 8, 16'h432E, 4'b1111, 4'b0000, 1'b1, 0};
        vecs[6]  = '{1'b1, 4'h7, 7'h7F, 1'b1, 8, 16'h0000, 4'b0000, 4'b0000, 1'b0, 0};
        vecs[7]  = '{1'b0, 4'h7, 7'h7E, 1'b1, 8, 16'h0000, 4'b0000, 4'b0000, 1'b1, 0};
        vecs[8]  = '{1'b1, 4'hE, 7'h00, 1'b1, 8, 16'h0008, 4'b0001, 4'b0000, 1'b0, 0};
        vecs[9]  = '{1'b0, 4'hD, 7'h00, 1'b1, 8, 16'h0088, 4'b0011, 4'b0000, 1'b0, 0};
        vecs[10] = '{1'b0, 4'hB, 7'h00, 1'b0, 8, 16'h0888, 4'b0111, 4'b0100, 1'b0, 0};
        vecs[11] = '{1'b0, 4'h7, 7'h00, 1'b1, 8, 16'h8888, 4'b1111, 4'b0100, 1'b0, 1};

        #2;
        do_reset();

        for (int v = 0; v < 12; v++) begin
            if (vecs[v].rst) do_reset();
            fd_cnt = 0;
            hold(vecs[v].an, vecs[v].seg, vecs[v].dp, vecs[v].cycles);
            check($sformatf("v%0d_digits", v), bus.digits, vecs[v].exp_digits);
            check($sformatf("v%0d_valid", v), 16'(bus.digit_valid), 16'(vecs[v].exp_valid));
            check($sformatf("v%0d_dp", v), 16'(bus.dp_out), 16'(vecs[v].exp_dp));
            check($sformatf("v%0d_err", v), 16'(bus.err), 16'(vecs[v].exp_err));
            check($sformatf("v%0d_frames", v), 16'(fd_cnt), 16'(vecs[v].exp_fd));
        end

        // Slot held too briefly is never captured.
        do_reset();
        fd_cnt = 0;
        hold(4'hE, 7'h40, 1'b1, 3);
        hold(4'hD, 7'h40, 1'b1, 8);
        check("short_valid", 16'(bus.digit_valid), 16'h0002);
        check("short_digits", bus.digits, 16'h0000);
        check("short_err", 16'(bus.err), 16'h0);
        check("short_frames", 16'(fd_cnt), 16'd0);

        // Reset mid-frame forgets the slots already seen.
        do_reset();
        hold(4'hE, 7'h79, 1'b1, 8);
        hold(4'hD, 7'h79, 1'b1, 8);
        do_reset();
        fd_cnt = 0;
        hold(4'hB, 7'h79, 1'b1, 8);
        hold(4'h7, 7'h79, 1'b1, 8);
        check("midrst_frames", 16'(fd_cnt), 16'd0);
        hold(4'hE, 7'h24, 1'b1, 8);
        hold(4'hD, 7'h24, 1'b1, 8);
        hold(4'hB, 7'h24, 1'b1, 8);
        hold(4'h7, 7'h24, 1'b1, 8);
        check("midrst_full", 16'(fd_cnt), 16'd1);
        check("midrst_digits", bus.digits, 16'h2222);

        // A long hold past the 8-bit counter range must not recapture the slot.
        do_reset();
        fd_cnt = 0;
        hold(4'hD, 7'h40, 1'b1, 8);
        hold(4'hB, 7'h40, 1'b1, 8);
        hold(4'h7, 7'h40, 1'b1, 8);
        hold(4'hE, 7'h40, 1'b1, 600);
        hold(4'hD, 7'h40, 1'b1, 8);
        hold(4'hB, 7'h40, 1'b1, 8);
        hold(4'h7, 7'h40, 1'b1, 8);
        check("longhold_frames", 16'(fd_cnt), 16'd1);
        check("longhold_valid", 16'(bus.digit_valid), 16'h000F);

        // Random scans, legal anodes first, then anything goes.
        for (int phase = 0; phase < 2; phase++) begin
            do_reset();
            for (int n = 0; n < 400; n++) begin
                logic [3:0] a;
                logic [6:0] s;
                logic       d;
                int         r;
                r = $urandom_range(0, 9);
                case (r)
                    0, 1: a = 4'hE;
                    2, 3: a = 4'hD;
                    4, 5: a = 4'hB;
                    6, 7: a = 4'h7;
                    8:    a = 4'hF;
                    default: a = (phase == 1) ? 4'($urandom) : 4'hE;
                endcase
                r = $urandom_range(0, 9);
                if (r < 8)       s = glyphs[$urandom_range(0, 15)];
                else if (r == 8) s = 7'h7F;
                else             s = (phase == 1) ? 7'($urandom) : glyphs[0];
                d = 1'($urandom);
                hold(a, s, d, $urandom_range(1, 10));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

Receive-side counterpart of the controller's multiplexed seven-segment output: samples `seg`/`an`/`dp`, waits for each scan slot to settle, decodes the active-low segment pattern back to a hex nibble, and assembles a full four-digit frame. Used in simulation benches and as on-chip loopback to check displayed time against expected values without eyeballing waveforms. Sits directly on the `seg`, `an`, `dp` nets of the display driver.

## Interface
- `SETTLE_CYCLES`, 4, consecutive identical input samples required before a capture (legal range 2..255)
- `MCLK`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `seg`  in  7  segment cathodes, active low, `seg[6:0]` = g,f,e,d,c,b,a
- `an`  in  4  digit anodes, active low, `an[3]` = leftmost digit
- `dp`  in  1  decimal point, active low
- `digits`  out  16  captured nibbles; `digits[4i+3:4i]` belongs to `an[i]`
- `dp_out`  out  4  captured decimal point per digit, active high
- `digit_valid`  out  4  per digit: last capture was a legal hex glyph
- `frame_done`  out  1  one-cycle pulse when all four digits have been captured since the previous pulse
- `err`  out  1  sticky; set on illegal glyph or multiple anodes low; cleared only by reset

## Operation
- Input stage: `{an,seg,dp}` registered once each `MCLK` edge into `in_q`; all logic works on `in_q`.
- Stability counter: 8-bit; clears to 0 when `in_q` differs from its previous value, else increments, saturating at `SETTLE_CYCLES`.
- Capture event: the cycle the counter transitions to `SETTLE_CYCLES - 1` (held value seen in `SETTLE_CYCLES` consecutive samples). Exactly one capture per stable period, regardless of how long it is held.
- Anode qualification at capture:
  - exactly one `an` bit low → capture into that slot
  - `an == 4'hF` → blank slot, no capture, no error
  - two or more bits low → no capture, `err` set
- Glyph decode, `seg` hex value → nibble: 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F.
  - `seg == 7'h7F` (blank): nibble 0, `digit_valid[i]` = 0, no error.
  - Any other pattern: nibble 0, `digit_valid[i]` = 0, `err` set.
  - Legal glyph: nibble written, `digit_valid[i]` = 1.
- `dp_out[i]` <= `~dp` on every capture into slot i, independent of glyph legality.
- Frame tracking: 4-bit `seen` mask; capture into slot i sets `seen[i]`. Capture that makes `seen == 4'hF` pulses `frame_done` and clears `seen` on the same edge. Recapturing an already-seen slot overwrites its data; no error, no effect on `seen`.
- Capture order is irrelevant; the driver may scan in any order.

## Timing
- Reset values: `digits` = 0, `dp_out` = 0, `digit_valid` = 0, `frame_done` = 0, `err` = 0, `seen` = 0, counter = 0, `in_q` = {4'hF,7'h7F,1'b1}.
- Latency: a value present at input edges t .. t+`SETTLE_CYCLES`-1 appears on `digits`/`dp_out`/`digit_valid` after edge t+`SETTLE_CYCLES` (one input register + settle window).
- `frame_done` is high exactly one cycle, coincident with the output update of the completing capture.
- Inputs changing faster than `SETTLE_CYCLES` samples: no capture, no error (treated as scan transition glitch).
- Reset asserted mid-frame: all outputs and `seen` clear asynchronously; first frame after release requires all four slots again.
- Counter saturation prevents wrap-around; a value held for 2^16 cycles does not recapture.

## Test plan
- Reset, then scan an=E,D,B,7 with seg=79,24,30,19, each held 8 cycles, `SETTLE_CYCLES`=4 → `digits`=16'h4321, `digit_valid`=4'hF, one `frame_done` pulse after 4th slot, `err`=0.
- Hold an=E seg=40 for 3 cycles then an=D seg=40 for 8 → slot 0 never captured, slot 1 = 0, no `frame_done`, `err`=0.
- an=C (two anodes low) held 8 cycles → `err`=1 and stays 1 after subsequent legal frames; `digits` unchanged.
- an=7 seg=7F held, then seg=7E held → first: `digits[15:12]`=0, `digit_valid[3]`=0, `err`=0; second: `err`=1.
- dp=0 on slot 2 only, full frame 8.8.8.8 pattern → `dp_out`=4'b0100, `digits`=16'h8888.
- Assert reset after two slots captured, release, scan remaining two → no `frame_done`; full four-slot scan then pulses once.
